mult_bist_misr: RTL and testbench
=================================

# mult_bist_misr

Multiple-input signature register (MISR) and BIST controller for the multiplier datapath. It is the response-side counterpart of the 16-bit pseudo-random operand generator. It compacts a programmed number of 16-bit products into a signature and compares that signature against a golden value. It sits at the multiplier output and reports a single pass/fail result to the test controller.

## Interface
- `WIDTH`, 16: product and signature width.
- `CNT_W`, 16: vector counter width.
- `clk` input 1: single clock; all state is updated on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a signature run; honoured only in IDLE or DONE.
- `num_vec` input CNT_W: number of products to compact; sampled when `start` is accepted.
- `golden` input WIDTH: expected signature; sampled when `start` is accepted.
- `p_valid` input 1: the product on `p` is valid this cycle.
- `p` input WIDTH: multiplier product.
- `busy` output 1: high while in RUN.
- `done` output 1: high while in DONE.
- `pass` output 1: compare result; meaningful only while `done` is high.
- `timeout` output 1: stall-timeout flag; tied to 0 unless `MISR_TIMEOUT_EN` is defined.
- `signature` output WIDTH: current MISR state.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset forces IDLE.
- Reset values: `busy`=0, `done`=0, `pass`=0, `timeout`=0, `signature`=16'hFFFF, counter=0.
- IDLE or DONE, with `start`=1:
  - signature is loaded with seed 16'hFFFF;
  - counter is loaded with `num_vec`;
  - `golden` is latched;
  - `done`, `pass` and `timeout` are cleared;
  - the next state is RUN, or DONE if `num_vec`=0.
- RUN, with `p_valid`=1: the MISR updates and the counter decrements. If the counter was 1, the next state is DONE.
- RUN, with `p_valid`=0: signature and counter hold.
- `start` is ignored in RUN; the run is not restarted.
- MISR update uses polynomial x^16+x^12+x^3+1, where s is the current state:
  - s'[0] = s[15]^p[0];
  - s'[3] = s[2]^s[15]^p[3];
  - s'[12] = s[11]^s[15]^p[12];
  - every other bit: s'[i] = s[i-1]^p[i].
- DONE entry: `pass` is registered as (final signature == latched golden). `done` and `pass` hold until the next accepted `start` or `reset`.
- Reset mid-run: the run is abandoned in the same edge and all outputs return to their reset values.
- `p` is don't-care whenever `p_valid`=0, and in IDLE and DONE.

## Timing
- `start` accepted at edge N: `busy`=1 from cycle N+1. With `num_vec`=0, `done`=1 from cycle N+1 instead.
- Each product is absorbed at the edge where `p_valid`=1, and `signature` reflects it in the next cycle.
- The last product is accepted at edge M. `busy`=0 and `done`=1 with valid `pass` from cycle M+1. There is no further latency.
- Back-to-back `p_valid` is supported at one product per cycle with no bubbles.
- `start` asserted in the same cycle as `done` starts a new run. The signature is reseeded at that edge.

## Configuration
- `MISR_TIMEOUT_EN` defined:
  - adds an 8-bit stall counter, cleared on every `p_valid` and on entry to RUN;
  - 255 consecutive cycles in RUN with `p_valid`=0 forces DONE with `timeout`=1 and `pass`=0;
  - `timeout` clears on the next accepted `start` or on `reset`.
- `MISR_TIMEOUT_EN` undefined: no stall counter, RUN waits indefinitely, and `timeout` is constant 0.

## Test plan
- Reset, then observe: `signature`=16'hFFFF, and `busy`, `done`, `pass`, `timeout` all 0.
- `num_vec`=1, `golden`=16'hEFF7, `start`, then one `p_valid` with `p`=16'h0000 -> `signature`=16'hEFF7 and `done`=1, `pass`=1 one cycle after the product. Repeat with `p`=16'h0001 -> `signature`=16'hEFF6, `pass`=0.
- `num_vec`=0, `golden`=16'hFFFF, `start` -> `done`=1 and `pass`=1 in the next cycle, `busy` never high.
- `num_vec`=256, product stream from the operand generator model with `p_valid` gapped randomly, `golden` from the reference model -> `pass`=1. Flip one bit of one product -> `pass`=0.
- `start` pulsed during RUN -> ignored, counter unaffected. `reset` asserted mid-run -> all outputs at reset values in the next cycle.
- With `MISR_TIMEOUT_EN`: RUN with `p_valid` held low for 255 cycles -> `done`=1, `timeout`=1, `pass`=0. With 254 idle cycles followed by a valid product -> no timeout.

Source files
------------

// File: rtl/mult_bist_misr.sv
// Response-side BIST block: compacts a programmed number of products into a 16-bit MISR
// signature and compares it with a golden value. Optional stall timeout via MISR_TIMEOUT_EN.
module mult_bist_misr #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [WIDTH-1:0] golden,
    input  logic             p_valid,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [WIDTH-1:0] signature
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Feedback taps of x^16+x^12+x^3+1: the bit shifted out of s[15] re-enters at bits 0, 3 and 12.
    localparam logic [WIDTH-1:0] POLY = WIDTH'(16'h1009);
    localparam logic [WIDTH-1:0] SEED = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] golden_q, golden_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] misr_next;

`ifdef MISR_TIMEOUT_EN
    logic [7:0]       stall_q, stall_d;
    logic             timeout_q, timeout_d;
`endif

    assign misr_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ p;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        golden_d = golden_q;
        pass_d   = pass_q;
`ifdef MISR_TIMEOUT_EN
        stall_d   = stall_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sig_d    = SEED;
                    cnt_d    = num_vec;
                    golden_d = golden;
                    pass_d   = 1'b0;
`ifdef MISR_TIMEOUT_EN
                    stall_d   = '0;
                    timeout_d = 1'b0;
`endif
                    if (num_vec == '0) begin
                        // Empty run: the seed itself is the final signature.
                        state_d = ST_DONE;
                        pass_d  = (SEED == golden);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (p_valid) begin
                    sig_d = misr_next;
                    cnt_d = cnt_q - CNT_W'(1);
`ifdef MISR_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        pass_d  = (misr_next == golden_q);
                    end
                end
`ifdef MISR_TIMEOUT_EN
                // The 255th consecutive idle cycle sees a count of 254 and aborts the run.
                else if (stall_q == 8'd254) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    stall_d = stall_q + 8'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sig_q    <= SEED;
            cnt_q    <= '0;
            golden_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            golden_q <= golden_d;
            pass_q   <= pass_d;
        end
    end

`ifdef MISR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_mult_bist_misr.sv
// Self-checking bench for mult_bist_misr: directed steps plus a randomized product stream
// checked against a bit-rule MISR reference model. Timeout steps run when MISR_TIMEOUT_EN is defined.
module tb_mult_bist_misr;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num_vec;
  logic [15:0] golden;
  logic        p_valid;
  logic [15:0] p;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] signature;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] prods[$];

  mult_bist_misr #(.WIDTH(16), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_vec   (num_vec),
    .golden    (golden),
    .p_valid   (p_valid),
    .p         (p),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .signature (signature)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_fail++;
      $error("FAIL %s (signature=%0h busy=%0b done=%0b pass=%0b timeout=%0b)",
             tag, signature, busy, done, pass, timeout);
    end
  endtask

  // Reference MISR step written directly from the per-bit rules.
  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [15:0] d);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       r[i] = s[15] ^ d[0];
        3:       r[i] = s[2] ^ s[15] ^ d[3];
        12:      r[i] = s[11] ^ s[15] ^ d[12];
        default: r[i] = s[i-1] ^ d[i];
      endcase
    end
    return r;
  endfunction

  // Operand generator model: 16-bit Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] fold(input int flip_idx);
    logic [15:0] s;
    logic [15:0] d;
    s = 16'hFFFF;
    for (int k = 0; k < prods.size(); k++) begin
      d = prods[k];
      if (k == flip_idx) d ^= 16'h0010;
      s = misr_ref(s, d);
    end
    return s;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    p_valid = 1'b0;
    p       = 16'($urandom);
    next_cycle();
  endtask

  task automatic drive_start(input logic [15:0] n, input logic [15:0] g);
    start   = 1'b1;
    num_vec = n;
    golden  = g;
    next_cycle();
    start   = 1'b0;
    num_vec = 16'($urandom);
    golden  = 16'($urandom);
  endtask

  task automatic feed(input logic [15:0] val);
    p_valid = 1'b1;
    p       = val;
    next_cycle();
    p_valid = 1'b0;
    p       = 16'($urandom);
  endtask

  task automatic run_stream(input int flip_idx, input logic [15:0] gold, input logic exp_pass);
    logic [15:0] model;
    logic [15:0] d;
    model = 16'hFFFF;
    drive_start(16'(prods.size()), gold);
    check("stream busy after start", busy === 1'b1);
    check("stream done cleared", done === 1'b0);
    for (int k = 0; k < prods.size(); k++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      d = prods[k];
      if (k == flip_idx) d ^= 16'h0010;
      if (k == prods.size() - 1) check("stream busy before last", busy === 1'b1);
      feed(d);
      model = misr_ref(model, d);
      check("stream signature", signature === model);
    end
    check("stream done", done === 1'b1);
    check("stream busy low", busy === 1'b0);
    check("stream pass", pass === exp_pass);
    check("stream timeout", timeout === 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] full;
    logic [15:0] gold;
    logic [15:0] model;

    reset   = 1'b1;
    start   = 1'b0;
    num_vec = '0;
    golden  = '0;
    p_valid = 1'b0;
    p       = 16'($urandom);
    repeat (2) next_cycle();
    reset = 1'b0;

    // Reset state
    check("reset signature", signature === 16'hFFFF);
    check("reset busy", busy === 1'b0);
    check("reset done", done === 1'b0);
    check("reset pass", pass === 1'b0);
    check("reset timeout", timeout === 1'b0);

    // Single product 0 -> EFF7, matching golden
    drive_start(16'd1, 16'hEFF7);
    check("single busy", busy === 1'b1);
    feed(16'h0000);
    check("single0 signature", signature === 16'hEFF7);
    check("single0 done", done === 1'b1);
    check("single0 pass", pass === 1'b1);
    check("single0 busy", busy === 1'b0);

    // Single product 1 -> EFF6, restarted directly from DONE
    drive_start(16'd1, 16'hEFF7);
    check("restart done cleared", done === 1'b0);
    check("restart pass cleared", pass === 1'b0);
    check("restart reseeded", signature === 16'hFFFF);
    feed(16'h0001);
    check("single1 signature", signature === 16'hEFF6);
    check("single1 done", done === 1'b1);
    check("single1 pass", pass === 1'b0);

    // Empty run: done next cycle, busy never high
    drive_start(16'd0, 16'hFFFF);
    check("empty done", done === 1'b1);
    check("empty pass", pass === 1'b1);
    check("empty busy", busy === 1'b0);
    idle_cycle();
    check("empty busy hold", busy === 1'b0);
    check("empty done hold", done === 1'b1);

    // 256 products from the operand generator model, gapped randomly
    a = 16'($urandom_range(1, 65535));
    b = 16'($urandom_range(1, 65535));
    prods.delete();
    for (int k = 0; k < 256; k++) begin
      a = lfsr_next(a);
      b = lfsr_next(lfsr_next(b));
      full = 32'(a) * 32'(b);
      prods.push_back(full[15:0]);
    end
    gold = fold(-1);
    run_stream(-1, gold, 1'b1);
    // Same stream with one bit flipped in product 100
    run_stream(100, gold, 1'b0);

    // start pulsed during RUN is ignored
    prods.delete();
    for (int k = 0; k < 4; k++) prods.push_back(16'($urandom));
    gold = fold(-1);
    model = 16'hFFFF;
    drive_start(16'd4, gold);
    for (int k = 0; k < 2; k++) begin
      feed(prods[k]);
      model = misr_ref(model, prods[k]);
    end
    drive_start(16'd1, 16'h0000);
    check("ignored start busy", busy === 1'b1);
    check("ignored start signature", signature === model);
    feed(prods[2]);
    check("ignored start count busy", busy === 1'b1);
    check("ignored start count done", done === 1'b0);
    feed(prods[3]);
    check("ignored start final done", done === 1'b1);
    check("ignored start final pass", pass === 1'b1);
    check("ignored start final sig", signature === gold);

    // Reset mid-run
    drive_start(16'd10, 16'h1234);
    feed(16'($urandom));
    feed(16'($urandom));
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    check("midreset signature", signature === 16'hFFFF);
    check("midreset busy", busy === 1'b0);
    check("midreset done", done === 1'b0);
    check("midreset pass", pass === 1'b0);
    check("midreset timeout", timeout === 1'b0);
    feed(16'($urandom));
    check("midreset stays idle", busy === 1'b0);
    check("midreset sig holds", signature === 16'hFFFF);

`ifdef MISR_TIMEOUT_EN
    // 254 idle cycles then a product: no timeout
    drive_start(16'd2, 16'h0000);
    repeat (254) idle_cycle();
    check("stall254 busy", busy === 1'b1);
    feed(16'h0000);
    check("stall254 still busy", busy === 1'b1);
    check("stall254 timeout", timeout === 1'b0);
    // 255 idle cycles: forced DONE with timeout
    repeat (254) idle_cycle();
    check("stall255 busy before", busy === 1'b1);
    idle_cycle();
    check("stall255 done", done === 1'b1);
    check("stall255 timeout", timeout === 1'b1);
    check("stall255 pass", pass === 1'b0);
    check("stall255 busy", busy === 1'b0);
    drive_start(16'd1, 16'h0000);
    check("timeout cleared by start", timeout === 1'b0);
`else
    // Without the timeout option RUN waits indefinitely
    drive_start(16'd1, 16'hEFF7);
    repeat (300) idle_cycle();
    check("no timeout busy", busy === 1'b1);
    check("no timeout flag", timeout === 1'b0);
    feed(16'h0000);
    check("no timeout late pass", pass === 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
